// File: rtl/test_merge_header.sv
// test_merge_header: prepends a 32-bit header beat to each 512-bit payload packet.
// Ports:
//   clock, reset                       - single clock, synchronous active-high reset
//   io_in_meta_*                       - header handshake: header word and empty flag
//   io_in_data_*                       - payload beats: last, data, keep
//   io_out_data_*                      - merged stream from one output register
//   io_pkt_count                       - packets fully loaded into the output register
module test_merge_header (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_meta_valid,
  output logic         io_in_meta_ready,
  input  logic [31:0]  io_in_meta_bits_header,
  input  logic         io_in_meta_bits_empty,
  input  logic         io_in_data_valid,
  output logic         io_in_data_ready,
  input  logic         io_in_data_bits_last,
  input  logic [511:0] io_in_data_bits_data,
  input  logic [63:0]  io_in_data_bits_keep,
  output logic         io_out_data_valid,
  input  logic         io_out_data_ready,
  output logic         io_out_data_bits_last,
  output logic [511:0] io_out_data_bits_data,
  output logic [63:0]  io_out_data_bits_keep,
  output logic [31:0]  io_pkt_count
);
  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;
  state_t state, state_nxt;
  logic load_en, meta_fire, data_fire;
  // the register can take a new beat when empty or being drained this cycle
  assign load_en = !io_out_data_valid || io_out_data_ready;
  assign meta_fire = io_in_meta_valid && io_in_meta_ready;
  assign data_fire = io_in_data_valid && io_in_data_ready;
  always_ff @(posedge clock)
    state <= reset ? S_IDLE : state_nxt;
  always_comb
    state_nxt = (state == S_IDLE) ? ((meta_fire && !io_in_meta_bits_empty) ? S_PAYLOAD : S_IDLE)
                                  : ((data_fire && io_in_data_bits_last) ? S_IDLE : S_PAYLOAD);
  // readies are gated by reset so nothing is accepted while it is held
  always_comb begin
    io_in_meta_ready = !reset && state == S_IDLE && load_en;
    io_in_data_ready = !reset && state == S_PAYLOAD && load_en;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_data_valid     <= 1'b0;
      io_out_data_bits_last <= 1'b0;
      io_out_data_bits_data <= '0;
      io_out_data_bits_keep <= '0;
      io_pkt_count          <= '0;
    end else begin
      if (meta_fire) begin
        io_out_data_valid     <= 1'b1;
        io_out_data_bits_last <= io_in_meta_bits_empty;
        io_out_data_bits_data <= {480'b0, io_in_meta_bits_header};
        io_out_data_bits_keep <= '1;
      end else if (data_fire) begin
        io_out_data_valid     <= 1'b1;
        io_out_data_bits_last <= io_in_data_bits_last;
        io_out_data_bits_data <= io_in_data_bits_data;
        io_out_data_bits_keep <= io_in_data_bits_keep;
      end else if (io_out_data_ready) begin
        io_out_data_valid     <= 1'b0;
      end
      if ((meta_fire && io_in_meta_bits_empty) || (data_fire && io_in_data_bits_last))
        io_pkt_count <= io_pkt_count + 32'd1;
    end
  end
endmodule
